// File: rtl/reg_access_ctrl.sv
// Instruction sequencer for an external 8-entry register file: fetches operands,
// runs a small ALU and writes the result back through the rf_* port.
module reg_access_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic [ADDR_WIDTH-1:0] instr_ra,
  input  logic [ADDR_WIDTH-1:0] instr_rb,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  output logic                  rf_enable,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_rd_adrs,
  output logic [ADDR_WIDTH-1:0] rf_ra_adrs,
  output logic [ADDR_WIDTH-1:0] rf_rb_adrs,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  input  logic [DATA_WIDTH-1:0] rf_ra_out,
  input  logic [DATA_WIDTH-1:0] rf_rb_out,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero,
  output logic                  done
);

  // state   | meaning
  // S_IDLE  | ready for an instruction; NOP completes here
  // S_READ  | register file reads ra/rb
  // S_EXEC  | operands valid, ALU result and flags registered
  // S_WRITE | result written to rd
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] rf_rd_adrs_q, rf_rd_adrs_d;
  logic [ADDR_WIDTH-1:0] rf_ra_adrs_q, rf_ra_adrs_d;
  logic [ADDR_WIDTH-1:0] rf_rb_adrs_q, rf_rb_adrs_d;
  logic [DATA_WIDTH-1:0] rf_data_in_q, rf_data_in_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  carry_q, carry_d;
  logic                  zero_q, zero_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH:0]   sum_w, diff_w;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;

  assign sum_w  = {1'b0, rf_ra_out} + {1'b0, rf_rb_out};
  assign diff_w = {1'b0, rf_ra_out} - {1'b0, rf_rb_out};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum_w[DATA_WIDTH-1:0];
        alu_carry = sum_w[DATA_WIDTH];
      end
      // the 17th bit of the widened difference is the unsigned borrow
      OP_SUB: begin
        alu_res   = diff_w[DATA_WIDTH-1:0];
        alu_carry = diff_w[DATA_WIDTH];
      end
      OP_AND:  alu_res = rf_ra_out & rf_rb_out;
      OP_OR:   alu_res = rf_ra_out | rf_rb_out;
      OP_XOR:  alu_res = rf_ra_out ^ rf_rb_out;
      OP_MOV:  alu_res = rf_ra_out;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rf_rd_adrs_d = rf_rd_adrs_q;
    rf_ra_adrs_d = rf_ra_adrs_q;
    rf_rb_adrs_d = rf_rb_adrs_q;
    rf_data_in_d = rf_data_in_q;
    result_d     = result_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d = instr_op;
          rd_d = instr_rd;
          case (instr_op)
            OP_LOAD: begin
              result_d     = instr_imm;
              carry_d      = 1'b0;
              zero_d       = (instr_imm == '0);
              rf_rd_adrs_d = instr_rd;
              rf_data_in_d = instr_imm;
              state_d      = S_WRITE;
            end
            OP_NOP: done_d = 1'b1;
            default: begin
              rf_ra_adrs_d = instr_ra;
              rf_rb_adrs_d = instr_rb;
              state_d      = S_READ;
            end
          endcase
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        result_d     = alu_res;
        carry_d      = alu_carry;
        zero_d       = (alu_res == '0);
        rf_rd_adrs_d = rd_q;
        rf_data_in_d = alu_res;
        state_d      = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      rf_rd_adrs_q <= '0;
      rf_ra_adrs_q <= '0;
      rf_rb_adrs_q <= '0;
      rf_data_in_q <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      rf_rd_adrs_q <= rf_rd_adrs_d;
      rf_ra_adrs_q <= rf_ra_adrs_d;
      rf_rb_adrs_q <= rf_rb_adrs_d;
      rf_data_in_q <= rf_data_in_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      done_q       <= done_d;
    end
  end

  // gated by reset_n so a reset landing in S_WRITE cannot commit a write
  assign rf_enable   = reset_n && (state_q == S_READ || state_q == S_WRITE);
  assign rf_wr_en    = reset_n && (state_q == S_WRITE);
  assign instr_ready = (state_q == S_IDLE);
  assign rf_rd_adrs  = rf_rd_adrs_q;
  assign rf_ra_adrs  = rf_ra_adrs_q;
  assign rf_rb_adrs  = rf_rb_adrs_q;
  assign rf_data_in  = rf_data_in_q;
  assign result      = result_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign done        = done_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural 8-entry register file
// (registered reads) attached to its rf_* port.
module tb_reg_access_ctrl;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [2:0]  instr_rd, instr_ra, instr_rb;
  logic [15:0] instr_imm;
  logic        rf_enable, rf_wr_en;
  logic [2:0]  rf_rd_adrs, rf_ra_adrs, rf_rb_adrs;
  logic [15:0] rf_data_in;
  logic [15:0] rf_ra_out, rf_rb_out;
  logic [15:0] result;
  logic        carry, zero, done;

  int checks = 0;
  int failures = 0;

  logic [15:0] regs [8];
  logic [2:0]  last_wr_addr;
  logic [15:0] last_wr_data;
  int          wr_count = 0;
  logic        enable_seen;

  localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, SUB = 3'b010, XOR = 3'b101,
                         MOV = 3'b110, NOP = 3'b111;

  reg_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_imm(instr_imm),
    .rf_enable(rf_enable), .rf_wr_en(rf_wr_en),
    .rf_rd_adrs(rf_rd_adrs), .rf_ra_adrs(rf_ra_adrs), .rf_rb_adrs(rf_rb_adrs),
    .rf_data_in(rf_data_in), .rf_ra_out(rf_ra_out), .rf_rb_out(rf_rb_out),
    .result(result), .carry(carry), .zero(zero), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    rf_ra_out    = 16'h0000;
    rf_rb_out    = 16'h0000;
    last_wr_addr = 3'd0;
    last_wr_data = 16'h0000;
    enable_seen  = 1'b0;
  end

  always @(posedge clock) begin
    if (rf_enable) enable_seen <= 1'b1;
    if (rf_enable && rf_wr_en) begin
      regs[rf_rd_adrs] <= rf_data_in;
      last_wr_addr     <= rf_rd_adrs;
      last_wr_data     <= rf_data_in;
      wr_count         <= wr_count + 1;
    end else if (rf_enable) begin
      rf_ra_out <= regs[rf_ra_adrs];
      rf_rb_out <= regs[rf_rb_adrs];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Issues one instruction, scrambles the inputs after acceptance, then waits for done.
  // Returns at #1 after the edge that raised done.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm,
                        input int exp_lat);
    int lat;
    int w;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(posedge clock); #1;
      w++;
    end
    chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    instr_op = 3'($urandom); instr_rd = 3'($urandom);
    instr_ra = 3'($urandom); instr_rb = 3'($urandom); instr_imm = 16'($urandom);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clock); #1;
    end
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  int          wr_before;
  logic        done_seen;

  initial begin
    reset_n = 1'b0;
    instr_valid = 1'b0;
    instr_op = NOP; instr_rd = '0; instr_ra = '0; instr_rb = '0; instr_imm = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_enable", rf_enable, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_data_in", rf_data_in, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_op("load_r1", LOAD, 3'd1, 3'd0, 3'd0, 16'h1234, 1);
    chk("load_r1_result", result, 16'h1234);
    chk("load_r1_wr", {last_wr_addr, last_wr_data}, {3'd1, 16'h1234});
    run_op("load_r2", LOAD, 3'd2, 3'd0, 3'd0, 16'h0001, 1);
    run_op("add_r3", ADD, 3'd3, 3'd1, 3'd2, 16'h0000, 3);
    chk("add_r3_wr", {last_wr_addr, last_wr_data}, {3'd3, 16'h1235});
    chk("add_r3_flags", {carry, zero}, 2'b00);

    run_op("load_ffff", LOAD, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1);
    chk("load_ffff_flags", {carry, zero}, 2'b00);
    run_op("add_r4", ADD, 3'd4, 3'd1, 3'd2, 16'h0000, 3);
    chk("add_r4_result", result, 16'h0000);
    chk("add_r4_flags", {carry, zero}, 2'b11);
    chk("add_r4_wr", {last_wr_addr, last_wr_data}, {3'd4, 16'h0000});

    run_op("load_r1_2", LOAD, 3'd1, 3'd0, 3'd0, 16'h0002, 1);
    run_op("sub_r5", SUB, 3'd5, 3'd2, 3'd1, 16'h0000, 3);
    chk("sub_r5_result", result, 16'hFFFF);
    chk("sub_r5_flags", {carry, zero}, 2'b10);
    run_op("xor_r5", XOR, 3'd5, 3'd5, 3'd5, 16'h0000, 3);
    chk("xor_r5_result", result, 16'h0000);
    chk("xor_r5_flags", {carry, zero}, 2'b01);
    chk("xor_r5_reg", regs[5], 16'h0000);

    run_op("load_r1_3", LOAD, 3'd1, 3'd0, 3'd0, 16'h0003, 1);
    run_op("add_r1", ADD, 3'd1, 3'd1, 3'd1, 16'h0000, 3);
    chk("add_r1_wr", {last_wr_addr, last_wr_data}, {3'd1, 16'h0006});
    run_op("mov_r6", MOV, 3'd6, 3'd1, 3'd0, 16'h0000, 3);
    chk("mov_r6_wr", {last_wr_addr, last_wr_data}, {3'd6, 16'h0006});
    chk("mov_r6_flags", {carry, zero}, 2'b00);

    // NOP held valid for three cycles: one done pulse per acceptance
    @(posedge clock); #1;
    enable_seen = 1'b0;
    instr_valid = 1'b1;
    instr_op = NOP; instr_rd = 3'd7; instr_ra = 3'd1; instr_rb = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk($sformatf("nop_done%0d", i), done, 1);
    end
    instr_valid = 1'b0;
    @(posedge clock); #1;
    chk("nop_done_end", done, 0);
    chk("nop_no_enable", enable_seen, 0);
    chk("nop_result", result, 16'h0006);
    chk("nop_flags", {carry, zero}, 2'b00);

    // reset landing in the WRITE cycle of ADD r7 must suppress the write
    run_op("load_r7", LOAD, 3'd7, 3'd0, 3'd0, 16'hAAAA, 1);
    instr_valid = 1'b1;
    instr_op = ADD; instr_rd = 3'd7; instr_ra = 3'd1; instr_rb = 3'd6;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rw_in_write", rf_wr_en, 1);
    wr_before = wr_count;
    reset_n = 1'b0;
    #1;
    chk("rw_wr_en_forced", rf_wr_en, 0);
    chk("rw_enable_forced", rf_enable, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (done) done_seen = 1'b1;
    end
    chk("rw_no_done", done_seen, 0);
    chk("rw_no_write", wr_count, wr_before);
    chk("rw_r7_kept", regs[7], 16'hAAAA);
    chk("rw_result", result, 0);
    chk("rw_flags", {carry, zero}, 2'b00);
    chk("rw_rd_adrs", rf_rd_adrs, 0);
    chk("rw_data_in", rf_data_in, 0);
    chk("rw_ready", instr_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 16, register and data width.
REQ-002 Parameter ADDR_WIDTH, 3, register address width; the register file holds 8 entries.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr_ready  out  1  high only in IDLE; an instruction is accepted on a rising edge where instr_valid and instr_ready are both high.
REQ-007 instr_op  in  3  opcode: 000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MOV, 111 NOP.
REQ-008 instr_rd, instr_ra, instr_rb  in  ADDR_WIDTH each  destination, source A, source B.
REQ-009 instr_imm  in  DATA_WIDTH  immediate, used by LOAD only.
REQ-010 rf_enable, rf_wr_en  out  1 each  register-file enable and write select.
REQ-011 rf_rd_adrs, rf_ra_adrs, rf_rb_adrs  out  ADDR_WIDTH each  register-file addresses.
REQ-012 rf_data_in  out  DATA_WIDTH  write data.
REQ-013 rf_ra_out, rf_rb_out  in  DATA_WIDTH each  register-file read data; valid the cycle after a read edge.
REQ-014 result  out  DATA_WIDTH  last computed value, held until the next op.
REQ-015 carry, zero  out  1 each  flags of the last op.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, EXEC and WRITE.
REQ-018 On acceptance, the instruction fields SHALL be latched; later instr_* changes have no effect until the next acceptance.
REQ-019 Transition from IDLE on acceptance: ALU ops and MOV go to READ; LOAD goes to WRITE; NOP stays in IDLE.
REQ-020 READ: rf_enable=1, rf_wr_en=0, rf_ra_adrs/rf_rb_adrs = latched ra/rb; next state is EXEC.
REQ-021 EXEC: sample rf_ra_out/rf_rb_out, register result and flags; next state is WRITE.
REQ-022 WRITE: rf_enable=1, rf_wr_en=1, rf_rd_adrs=latched rd, rf_data_in=result; next state is IDLE.
REQ-023 In all other cycles, rf_enable=0 and rf_wr_en=0; the address and data outputs SHALL hold their last values.
REQ-024 ADD: {carry,result} = ra+rb, computed at 17 bits.
REQ-025 SUB: result = ra-rb mod 2^16; carry=1 iff ra<rb (unsigned borrow).
REQ-026 AND, OR, XOR, MOV (result=ra), LOAD (result=imm): carry=0.
REQ-027 zero SHALL equal (result==0) for every op except NOP.
REQ-028 For LOAD, result and flags SHALL be registered on the accept edge.
REQ-029 NOP SHALL leave result and flags unchanged.
REQ-030 done SHALL be high for exactly one cycle, the cycle after the WRITE edge; for NOP, it is the cycle after acceptance.
REQ-031 Latency from the accept edge E0: ALU/MOV write commits at edge E0+3 and done is high in cycle E0+3..E0+4; LOAD commits at E0+1.
REQ-032 Back-to-back operation: a new instruction MAY be accepted in the cycle done is high.
REQ-033 Read-after-write: a following op reading the just-written rd SHALL see the new value, because its READ edge follows the commit edge.
REQ-034 Reading and writing the same register in one op (e.g. rd=ra) SHALL be legal: the old value is read and the new value written.

Reset
REQ-035 While reset_n=0, rf_enable and rf_wr_en SHALL be forced to 0 combinationally, so no register-file write occurs even if reset hits during WRITE.
REQ-036 At a rising edge with reset_n=0: state=IDLE; result, carry, zero, done and all rf_* address/data outputs become 0; the latched instruction is discarded.
REQ-037 An operation interrupted mid-flight SHALL NOT complete after reset is released.

Verification
REQ-038 LOAD r1=0x1234, then LOAD r2=0x0001, then ADD r3=r1+r2 -> r3 write data 0x1235, carry=0, zero=0; done 3 cycles after the ADD accept edge.
REQ-039 LOAD r1=0xFFFF, r2=0x0001; ADD r4=r1+r2 -> result=0x0000, carry=1, zero=1.
REQ-040 SUB r5=r2-r1 with r2=0x0001 and r1=0x0002 -> result=0xFFFF, carry=1, zero=0; then XOR r5=r5^r5 -> result 0, zero=1, carry=0.
REQ-041 ADD r1=r1+r1 with r1=0x0003, immediately followed by MOV r6=r1 -> r6 receives 0x0006 (read-after-write).
REQ-042 reset_n=0 during the WRITE cycle of ADD r7 -> no write to r7 (rf_wr_en=0 throughout), all outputs 0, done never pulses.
REQ-043 NOP with instr_valid held high for 3 cycles -> 3 done pulses, rf_enable stays 0, result unchanged.
